// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - RV32I decode stage with registered control outputs
// and a load-use stall bubble.
module decode_ctrl_pipe #(
  parameter int XLEN      = 32,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             branch,
  output logic             memread,
  output logic             memtoreg,
  output logic             memwrite,
  output logic             alusrc,
  output logic             regwrite,
  output logic             jump,
  output logic             illegal,
  output logic [1:0]       ALUop,
  output logic [3:0]       ALUctr,
  output logic [2:0]       brfunct,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0110,
                         ALU_SRL = 4'b0111, ALU_SRA = 4'b1000, ALU_SLT = 4'b1001,
                         ALU_SLTU = 4'b1010, ALU_PASSB = 4'b1011;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       br_d, mr_d, mtr_d, mw_d, as_d, rw_d, j_d, ill_d, use_rs1, use_rs2;
  logic [1:0] aluop_d;
  logic [3:0] aluctr_d;
  logic [31:0] imm32;
  logic       advance, hz;

  assign opc = instruction[6:0];
  assign f3  = instruction[14:12];

  always_comb begin
    br_d = 1'b0; mr_d = 1'b0; mtr_d = 1'b0; mw_d = 1'b0; as_d = 1'b0;
    rw_d = 1'b0; j_d = 1'b0; ill_d = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    aluop_d = 2'b00; aluctr_d = ALU_ADD; imm32 = 32'd0;
    case (opc)
      7'b0110011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; aluop_d = 2'b10; rw_d = 1'b1;
        case ({instruction[30], f3})
          4'b0000: aluctr_d = ALU_ADD;
          4'b1000: aluctr_d = ALU_SUB;
          4'b0001: aluctr_d = ALU_SLL;
          4'b0010: aluctr_d = ALU_SLT;
          4'b0011: aluctr_d = ALU_SLTU;
          4'b0100: aluctr_d = ALU_XOR;
          4'b0101: aluctr_d = ALU_SRL;
          4'b1101: aluctr_d = ALU_SRA;
          4'b0110: aluctr_d = ALU_OR;
          4'b0111: aluctr_d = ALU_AND;
          default: ill_d = 1'b1;
        endcase
      end
      7'b0010011: begin
        use_rs1 = 1'b1; aluop_d = 2'b10; as_d = 1'b1; rw_d = 1'b1;
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
        case (f3)
          3'b000: aluctr_d = ALU_ADD;
          3'b010: aluctr_d = ALU_SLT;
          3'b011: aluctr_d = ALU_SLTU;
          3'b100: aluctr_d = ALU_XOR;
          3'b110: aluctr_d = ALU_OR;
          3'b111: aluctr_d = ALU_AND;
          3'b001: aluctr_d = ALU_SLL;
          default: aluctr_d = instruction[30] ? ALU_SRA : ALU_SRL;
        endcase
      end
      7'b0000011: begin
        use_rs1 = 1'b1; mr_d = 1'b1; mtr_d = 1'b1; as_d = 1'b1; rw_d = 1'b1;
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      end
      7'b0100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; mw_d = 1'b1; as_d = 1'b1;
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      7'b1100011: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; br_d = 1'b1; aluop_d = 2'b01;
        imm32 = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                 instruction[11:8], 1'b0};
        case (f3[2:1])
          2'b00: aluctr_d = ALU_SUB;
          2'b10: aluctr_d = ALU_SLT;
          2'b11: aluctr_d = ALU_SLTU;
          default: ill_d = 1'b1;
        endcase
      end
      7'b0110111: begin
        aluctr_d = ALU_PASSB; as_d = 1'b1; rw_d = 1'b1;
        imm32 = {instruction[31:12], 12'd0};
      end
      7'b0010111: begin
        as_d = 1'b1; rw_d = 1'b1;
        imm32 = {instruction[31:12], 12'd0};
      end
      7'b1101111: begin
        j_d = 1'b1; as_d = 1'b1; rw_d = 1'b1;
        imm32 = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                 instruction[30:21], 1'b0};
      end
      7'b1100111: begin
        use_rs1 = 1'b1; j_d = 1'b1; as_d = 1'b1; rw_d = 1'b1;
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      end
      default: ill_d = 1'b1;
    endcase
    // An illegal word carries no control, no operands and no immediate.
    if (ill_d) begin
      br_d = 1'b0; mr_d = 1'b0; mtr_d = 1'b0; mw_d = 1'b0; as_d = 1'b0;
      rw_d = 1'b0; j_d = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
      aluop_d = 2'b00; aluctr_d = ALU_ADD; imm32 = 32'd0;
    end
  end

  assign advance  = out_ready || !out_valid;
  assign hz       = HAZARD_EN && out_valid && memread && (rd != 5'd0) && in_valid &&
                    ((use_rs1 && instruction[19:15] == rd) ||
                     (use_rs2 && instruction[24:20] == rd));
  assign in_ready = !rst && (flush || (advance && !hz));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0; branch <= 1'b0; memread <= 1'b0; memtoreg <= 1'b0;
      memwrite <= 1'b0; alusrc <= 1'b0; regwrite <= 1'b0; jump <= 1'b0;
      illegal <= 1'b0; ALUop <= 2'b00; ALUctr <= 4'b0000; brfunct <= 3'd0;
      rs1 <= 5'd0; rs2 <= 5'd0; rd <= 5'd0; imm <= '0;
      stall_cnt <= '0; flush_cnt <= '0;
    end else begin
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      if (!flush && advance && hz && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      // Flush, load-use bubble and an empty advance all load a dead stage.
      if (flush || (advance && (hz || !in_valid))) begin
        out_valid <= 1'b0; branch <= 1'b0; memread <= 1'b0; memtoreg <= 1'b0;
        memwrite <= 1'b0; alusrc <= 1'b0; regwrite <= 1'b0; jump <= 1'b0;
        illegal <= 1'b0; ALUop <= 2'b00; ALUctr <= 4'b0000; brfunct <= 3'd0;
        rs1 <= 5'd0; rs2 <= 5'd0; rd <= 5'd0; imm <= '0;
      end else if (advance) begin
        out_valid <= 1'b1; branch <= br_d; memread <= mr_d; memtoreg <= mtr_d;
        memwrite <= mw_d; alusrc <= as_d; regwrite <= rw_d; jump <= j_d;
        illegal <= ill_d; ALUop <= aluop_d; ALUctr <= aluctr_d;
        brfunct <= br_d ? f3 : 3'd0;
        rs1 <= instruction[19:15]; rs2 <= instruction[24:20]; rd <= instruction[11:7];
        imm <= XLEN'($signed(imm32));
      end
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb/tb_decode_ctrl_pipe.sv - directed bench for decode_ctrl_pipe; a second
// instance with the hazard unit disabled shares the same stimulus.
module tb_decode_ctrl_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, flush, out_ready;
  logic [31:0] instruction;
  int total = 0;
  int fails = 0;

  logic in_ready, out_valid, branch, memread, memtoreg, memwrite, alusrc, regwrite, jump, illegal;
  logic [1:0] ALUop;
  logic [3:0] ALUctr;
  logic [2:0] brfunct;
  logic [4:0] rs1, rs2, rd;
  logic [31:0] imm;
  logic [15:0] stall_cnt, flush_cnt;

  logic in_ready_n, out_valid_n, branch_n, memread_n, memtoreg_n, memwrite_n, alusrc_n;
  logic regwrite_n, jump_n, illegal_n;
  logic [1:0] ALUop_n;
  logic [3:0] ALUctr_n;
  logic [2:0] brfunct_n;
  logic [4:0] rs1_n, rs2_n, rd_n;
  logic [31:0] imm_n;
  logic [15:0] stall_cnt_n, flush_cnt_n;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.XLEN(32), .HAZARD_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .branch(branch), .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite),
    .alusrc(alusrc), .regwrite(regwrite), .jump(jump), .illegal(illegal),
    .ALUop(ALUop), .ALUctr(ALUctr), .brfunct(brfunct), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  decode_ctrl_pipe #(.XLEN(32), .HAZARD_EN(1'b0), .CNT_W(16)) dut_nohz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .instruction(instruction), .flush(flush), .out_valid(out_valid_n), .out_ready(out_ready),
    .branch(branch_n), .memread(memread_n), .memtoreg(memtoreg_n), .memwrite(memwrite_n),
    .alusrc(alusrc_n), .regwrite(regwrite_n), .jump(jump_n), .illegal(illegal_n),
    .ALUop(ALUop_n), .ALUctr(ALUctr_n), .brfunct(brfunct_n), .rs1(rs1_n), .rs2(rs2_n),
    .rd(rd_n), .imm(imm_n), .stall_cnt(stall_cnt_n), .flush_cnt(flush_cnt_n));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; instruction = 32'h40208133; flush = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if ({regwrite, ALUop, ALUctr, rd, imm} !== 44'd0) begin fails++; $display("FAIL reset_fields got %h want 0", {regwrite, ALUop, ALUctr, rd, imm}); end
    total++; if ({stall_cnt, flush_cnt} !== 32'd0) begin fails++; $display("FAIL reset_counters got %h want 0", {stall_cnt, flush_cnt}); end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_sub();
    in_valid = 1'b1; instruction = 32'h40208133;
    #1;
    total++; if (in_ready !== 1'b1) begin fails++; $display("FAIL sub_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin fails++; $display("FAIL sub_out_valid got %b want 1", out_valid); end
    total++; if (ALUctr !== 4'b0001) begin fails++; $display("FAIL sub_aluctr got %b want 0001", ALUctr); end
    total++; if ({regwrite, alusrc, ALUop, rd} !== {1'b1, 1'b0, 2'b10, 5'd2}) begin fails++; $display("FAIL sub_ctrl got %b want 1010_00010", {regwrite, alusrc, ALUop, rd}); end
    tick();
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; instruction = 32'h0000A283;
    tick();
    total++; if ({out_valid, memread, memtoreg, rd} !== {3'b111, 5'd5}) begin fails++; $display("FAIL lw_out got %b want 111_00101", {out_valid, memread, memtoreg, rd}); end
    instruction = 32'h00728333;
    #1;
    total++; if (in_ready !== 1'b0) begin fails++; $display("FAIL lu_in_ready got %b want 0", in_ready); end
    total++; if (in_ready_n !== 1'b1) begin fails++; $display("FAIL nohz_in_ready got %b want 1", in_ready_n); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || regwrite !== 1'b0) begin fails++; $display("FAIL lu_bubble got %b%b want 00", out_valid, regwrite); end
    total++; if (stall_cnt !== 16'd1) begin fails++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
    total++; if (out_valid_n !== 1'b1 || rd_n !== 5'd6 || stall_cnt_n !== 16'd0) begin fails++; $display("FAIL nohz_add got %b %0d %0d want 1 6 0", out_valid_n, rd_n, stall_cnt_n); end
    total++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lu_retry_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if ({out_valid, regwrite, memread, ALUctr, rd} !== {3'b110, 4'b0000, 5'd6}) begin fails++; $display("FAIL lu_add got %b want 110_0000_00110", {out_valid, regwrite, memread, ALUctr, rd}); end
    total++; if (stall_cnt !== 16'd1) begin fails++; $display("FAIL lu_stall_hold got %0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_hold_flush();
    in_valid = 1'b1; instruction = 32'h4020D1B3;
    tick();
    total++; if ({out_valid, ALUctr, rd} !== {1'b1, 4'b1000, 5'd3}) begin fails++; $display("FAIL sra_out got %b want 1_1000_00011", {out_valid, ALUctr, rd}); end
    out_ready = 1'b0; instruction = 32'h00728333;
    #1;
    total++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1; tick();
    total++; if ({out_valid, ALUctr, rd, rs2} !== {1'b1, 4'b1000, 5'd3, 5'd2}) begin fails++; $display("FAIL hold_stable got %b want 1_1000_00011_00010", {out_valid, ALUctr, rd, rs2}); end
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    total++; if (flush_cnt !== 16'd1) begin fails++; $display("FAIL flush_cnt got %0d want 1", flush_cnt); end
    tick();
  endtask

  task automatic test_illegal_branch();
    in_valid = 1'b1; instruction = 32'hFFFFFFFF;
    tick();
    total++; if ({out_valid, illegal, regwrite, ALUctr} !== {3'b110, 4'b0000}) begin fails++; $display("FAIL illegal got %b want 110_0000", {out_valid, illegal, regwrite, ALUctr}); end
    instruction = 32'hFE20DEE3;
    tick();
    in_valid = 1'b0;
    total++; if ({branch, illegal, ALUop, ALUctr, brfunct} !== {2'b10, 2'b01, 4'b1001, 3'b101}) begin fails++; $display("FAIL bge_ctrl got %b want 10_01_1001_101", {branch, illegal, ALUop, ALUctr, brfunct}); end
    total++; if (imm !== 32'hFFFFFFFC) begin fails++; $display("FAIL bge_imm got %h want fffffffc", imm); end
    tick();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; instruction = 32'h0020A423;
    tick();
    total++; if ({memwrite, regwrite, alusrc, memread} !== 4'b1010 || imm !== 32'd8) begin fails++; $display("FAIL sw_out got %b %h want 1010 8", {memwrite, regwrite, alusrc, memread}, imm); end
    instruction = 32'h123453B7;
    tick();
    in_valid = 1'b0;
    total++; if ({ALUctr, regwrite, alusrc, rd} !== {4'b1011, 2'b11, 5'd7} || imm !== 32'h12345000) begin fails++; $display("FAIL lui_out got %b %h want 1011_11_00111 12345000", {ALUctr, regwrite, alusrc, rd}, imm); end
    tick();
    total++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_load_use();
    test_hold_flush();
    test_illegal_branch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end
endmodule
